// File: rtl/count_event_pkg.sv
// Shared constants for the counter-event FIFO: event codes, FSM states and record width.
// Record width grows by TS_W when COUNT_EVENT_FIFO_TIMESTAMP_EN is defined.
package count_event_pkg;

   localparam logic [1:0] EVT_NONE = 2'b00;
   localparam logic [1:0] EVT_WRAP = 2'b01;
   localparam logic [1:0] EVT_JUMP = 2'b10;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

`ifdef COUNT_EVENT_FIFO_TIMESTAMP_EN
   localparam int REC_TS_EN = 1;
`else
   localparam int REC_TS_EN = 0;
`endif

   function automatic int rec_width(input int w, input int ts_w);
      return 2 + 2 * w + REC_TS_EN * ts_w;
   endfunction

endpackage

// File: rtl/event_sync_fifo.sv
// Generic single-clock FIFO with extra-bit pointers; head data is shown combinationally
// and forced to zero while empty. A push into a full FIFO is accepted when a pop coincides.
module event_sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_push_ok
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop && !w_empty;
   assign w_push_ok = i_push && (!w_full || w_pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: the output is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push_ok && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_valid   = !w_empty;
   assign o_push_ok = w_push_ok;

endmodule

// File: rtl/count_event_fifo.sv
// Watches a free-running counter, queues WRAP/JUMP records, keeps saturating tallies and
// a sticky overflow flag. COUNT_EVENT_FIFO_TIMESTAMP_EN appends a cycle timestamp to each record.
module count_event_fifo
   import count_event_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int TS_W  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [W-1:0]                    value,
   input  logic                            clear,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [rec_width(W, TS_W)-1:0]   out_data,
   output logic [7:0]                      wrap_cnt,
   output logic [7:0]                      jump_cnt,
   output logic                            overflow
);

   localparam int RW = rec_width(W, TS_W);

   state_t         r_state;
   state_t         w_state_next;
   logic [W-1:0]   r_prev;
   logic [W-1:0]   w_prev_inc;
   logic [1:0]     w_evt;
   logic           w_push;
   logic           w_pop;
   logic           w_push_ok;
   logic [RW-1:0]  w_rec;
   logic [7:0]     r_wrap_cnt;
   logic [7:0]     r_jump_cnt;
   logic           r_overflow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_INIT;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (clear) w_state_next = ST_INIT;
      else       w_state_next = ST_TRACK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_prev <= '0;
      else        r_prev <= value;
   end

   assign w_prev_inc = r_prev + W'(1);

   // Wrap is tested first because FF->00 is also a modular increment.
   always_comb begin
      w_evt = EVT_NONE;
      if (r_state == ST_TRACK) begin
         if (r_prev == '1 && value == '0)                 w_evt = EVT_WRAP;
         else if (value == r_prev || value == w_prev_inc) w_evt = EVT_NONE;
         else                                             w_evt = EVT_JUMP;
      end
   end

   assign w_push = (w_evt != EVT_NONE) && !clear;
   assign w_pop  = out_valid && out_ready;

`ifdef COUNT_EVENT_FIFO_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     r_ts <= '0;
      else if (clear) r_ts <= '0;
      else            r_ts <= r_ts + TS_W'(1);
   end

   assign w_rec = {w_evt, r_prev, value, r_ts};
`else
   assign w_rec = {w_evt, r_prev, value};
`endif

   event_sync_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .i_clear   (clear),
      .i_push    (w_push),
      .i_data    (w_rec),
      .i_pop     (w_pop),
      .o_data    (out_data),
      .o_valid   (out_valid),
      .o_push_ok (w_push_ok)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrap_cnt <= '0;
         r_jump_cnt <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_wrap_cnt <= '0;
         r_jump_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok && w_evt == EVT_WRAP && r_wrap_cnt != 8'hFF)
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
         if (w_push_ok && w_evt == EVT_JUMP && r_jump_cnt != 8'hFF)
            r_jump_cnt <= r_jump_cnt + 8'd1;
         if (w_push && !w_push_ok)
            r_overflow <= 1'b1;
      end
   end

   assign wrap_cnt = r_wrap_cnt;
   assign jump_cnt = r_jump_cnt;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_count_event_fifo.sv
// Scoreboard bench for count_event_fifo: stimulus queues expected records, a negedge
// monitor pops and compares every accepted handshake.
module tb_count_event_fifo;

   localparam int W = 8;
`ifdef COUNT_EVENT_FIFO_TIMESTAMP_EN
   localparam int RW = 2 + 2 * W + 16;
`else
   localparam int RW = 2 + 2 * W;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          clear = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  value = '0;
   logic          out_valid;
   logic [RW-1:0] out_data;
   logic [7:0]    wrap_cnt;
   logic [7:0]    jump_cnt;
   logic          overflow;

   logic [17:0]   exp_q [$];
   logic [15:0]   ts_seen [$];
   logic [17:0]   mon_got;
   logic [17:0]   mon_want;
   logic [15:0]   ts_diff;
   int            n_tests = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   count_event_fifo dut (
      .clk       (clk),
      .reset     (reset),
      .value     (value),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .wrap_cnt  (wrap_cnt),
      .jump_cnt  (jump_cnt),
      .overflow  (overflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick(input logic [7:0] v);
      value = v;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rec(input logic [1:0] t, input logic [7:0] p, input logic [7:0] c);
      exp_q.push_back({t, p, c});
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         n_tests++;
         mon_got = out_data[RW-1 -: 18];
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL record: got %05h expected none", mon_got);
         end else begin
            mon_want = exp_q.pop_front();
            if (mon_got !== mon_want) begin
               n_fail++;
               $display("FAIL record: got %05h expected %05h", mon_got, mon_want);
            end else begin
               $display("ok   record: %05h", mon_got);
            end
`ifdef COUNT_EVENT_FIFO_TIMESTAMP_EN
            if (mon_got[17:16] == 2'b01) ts_seen.push_back(out_data[15:0]);
`endif
         end
      end
   end

   initial begin
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_wrap", wrap_cnt, 0);
      chk("rst_jump", jump_cnt, 0);
      chk("rst_ovf", overflow, 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      // Free-running counter through one wrap.
      tick(8'h00);
      for (int i = 1; i < 256; i++) tick(8'(i));
      expect_rec(2'b01, 8'hFF, 8'h00);
      tick(8'h00);
      tick(8'h01);
      tick(8'h02);
      chk("free_wrap_cnt", wrap_cnt, 1);
      chk("free_jump_cnt", jump_cnt, 0);
      chk("free_ovf", overflow, 0);
      chk("free_drained", exp_q.size(), 0);

      // Counter sync reset seen at 0x08.
      for (int i = 3; i <= 8; i++) tick(8'(i));
      chk("pre_jump_valid", out_valid, 0);
      expect_rec(2'b10, 8'h08, 8'h00);
      tick(8'h00);
      chk("jump_valid_lat1", out_valid, 1);
      tick(8'h01);
      chk("jump_popped", out_valid, 0);
      chk("jump_cnt", jump_cnt, 1);

      // Hold then resume.
      for (int i = 2; i <= 5; i++) tick(8'(i));
      repeat (10) tick(8'h05);
      tick(8'h06);
      tick(8'h07);
      chk("hold_wrap", wrap_cnt, 1);
      chk("hold_jump", jump_cnt, 1);
      chk("hold_valid", out_valid, 0);

      // Overflow: five jumps with the consumer stalled.
      clear = 1'b1;
      tick(8'h07);
      clear = 1'b0;
      tick(8'h07);
      out_ready = 1'b0;
      expect_rec(2'b10, 8'h07, 8'h40); tick(8'h40);
      expect_rec(2'b10, 8'h40, 8'h10); tick(8'h10);
      expect_rec(2'b10, 8'h10, 8'h20); tick(8'h20);
      expect_rec(2'b10, 8'h20, 8'h30); tick(8'h30);
      tick(8'h50);
      chk("ovf_set", overflow, 1);
      chk("ovf_jump_cnt", jump_cnt, 4);
      chk("ovf_head", out_data[RW-1 -: 18], {2'b10, 8'h07, 8'h40});
      out_ready = 1'b1;
      repeat (5) tick(8'h50);
      chk("ovf_drained", exp_q.size(), 0);
      chk("empty_data_zero", out_data, 0);
      out_ready = 1'b0;
      tick(8'h60);
      tick(8'h70);
      chk("pre_clear_valid", out_valid, 1);
      chk("pre_clear_jump", jump_cnt, 6);
      clear = 1'b1;
      tick(8'h99);
      clear = 1'b0;
      chk("clr_valid", out_valid, 0);
      chk("clr_wrap", wrap_cnt, 0);
      chk("clr_jump", jump_cnt, 0);
      chk("clr_ovf", overflow, 0);
      tick(8'h33);
      chk("post_clr_first", out_valid, 0);
      tick(8'h34);
      chk("post_clr_jump", jump_cnt, 0);

      // Full FIFO, pop coincides with a WRAP.
      expect_rec(2'b10, 8'h34, 8'hA0); tick(8'hA0);
      expect_rec(2'b10, 8'hA0, 8'hB0); tick(8'hB0);
      expect_rec(2'b10, 8'hB0, 8'hC0); tick(8'hC0);
      expect_rec(2'b10, 8'hC0, 8'hFF); tick(8'hFF);
      chk("full_ovf", overflow, 0);
      out_ready = 1'b1;
      expect_rec(2'b01, 8'hFF, 8'h00);
      tick(8'h00);
      out_ready = 1'b0;
      chk("full_wrap_cnt", wrap_cnt, 1);
      chk("full_ovf_after", overflow, 0);
      tick(8'h77);
      chk("still_full_ovf", overflow, 1);
      chk("still_full_jump", jump_cnt, 4);
      chk("full_head", out_data[RW-1 -: 18], {2'b10, 8'hA0, 8'hB0});
      out_ready = 1'b1;
      repeat (6) tick(8'h77);
      chk("full_drained", exp_q.size(), 0);

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      tick(8'h10);
      tick(8'h20);
      chk("pre_areset_valid", out_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("areset_valid", out_valid, 0);
      chk("areset_data", out_data, 0);
      chk("areset_jump", jump_cnt, 0);
      chk("areset_ovf", overflow, 0);
      exp_q.delete();
      ts_seen.delete();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      out_ready = 1'b1;
      tick(8'h00);
      for (int k = 0; k < 2; k++) begin
         for (int i = 1; i < 256; i++) tick(8'(i));
         expect_rec(2'b01, 8'hFF, 8'h00);
         tick(8'h00);
      end
      tick(8'h01);
      tick(8'h02);
      chk("rerun_wrap_cnt", wrap_cnt, 2);
      chk("rerun_jump_cnt", jump_cnt, 0);
      chk("rerun_drained", exp_q.size(), 0);
`ifdef COUNT_EVENT_FIFO_TIMESTAMP_EN
      chk("ts_count", ts_seen.size(), 2);
      if (ts_seen.size() == 2) begin
         ts_diff = ts_seen[1] - ts_seen[0];
         chk("ts_delta", ts_diff, 16'h0100);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
